// File: rtl/datapath_sequencer.sv
// rtl/datapath_sequencer.sv - multi-cycle fetch/decode/execute/writeback sequencer driving a register file and ALU
module datapath_sequencer #(
    parameter int PROG_LEN = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [3:0]       imem_addr,
    input  logic [31:0]      imem_data,
    output logic [4:0]       A1,
    output logic [4:0]       A2,
    output logic [4:0]       A3,
    output logic             WE3,
    output logic [2:0]       ALUControl,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_DONE
    } state_t;

    localparam logic [3:0] LAST_PC = 4'(PROG_LEN - 1);

    state_t      state;
    state_t      state_next;
    logic [3:0]  pc;
    logic [3:0]  pc_next;
    logic [31:0] ir;
    logic        at_last;
    logic        field_window;

    assign at_last = (pc == LAST_PC);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            pc      <= 4'd0;
            ir      <= 32'd0;
            retired <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (state == S_FETCH) begin
                ir <= imem_data;
            end
            if (state == S_IDLE && start) begin
                retired <= '0;
            end else if (state == S_WRITEBACK && retired != '1) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        case (state)
            S_IDLE: begin
                if (start) begin
                    pc_next    = 4'd0;
                    state_next = S_FETCH;
                end
            end
            S_FETCH: state_next = S_DECODE;
            S_DECODE: begin
                if (ir == 32'd0) begin
                    state_next = S_DONE;
                end else if (!ir[31]) begin
                    // no-op: skip execute/writeback and advance directly
                    if (at_last) begin
                        state_next = S_DONE;
                    end else begin
                        pc_next    = pc + 4'd1;
                        state_next = S_FETCH;
                    end
                end else begin
                    state_next = S_EXECUTE;
                end
            end
            S_EXECUTE: state_next = S_WRITEBACK;
            S_WRITEBACK: begin
                if (at_last) begin
                    state_next = S_DONE;
                end else begin
                    pc_next    = pc + 4'd1;
                    state_next = S_FETCH;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign field_window = (state == S_DECODE) || (state == S_EXECUTE) || (state == S_WRITEBACK);

    always_comb begin
        A1         = 5'd0;
        A2         = 5'd0;
        A3         = 5'd0;
        ALUControl = 3'd0;
        if (field_window) begin
            A1         = ir[25:21];
            A2         = ir[20:16];
            A3         = ir[15:11];
            ALUControl = ir[29:27];
        end
    end

    assign imem_addr = pc;
    assign WE3       = (state == S_WRITEBACK);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

endmodule
